pong_paddle_ctrl: RTL and testbench

- Drives one paddle's vertical position, `paddle_y`, into the ball/collision logic.
- It is the producer side of the paddle/ball interface: it consumes the ball position and returns a paddle position.
- Two modes: player mode (up/down buttons) and AI mode (tracks the ball with a reaction delay and a speed limit).
- One instance per side; the side is selected by parameter.

---
 rtl/pong_pkg.sv | 17 +
 rtl/pong_paddle_ctrl_clamp_step.sv | 46 ++++
 rtl/pong_paddle_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pong_paddle_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Screen geometry and AI state encoding shared by the paddle, ball and collision logic.
package pong_pkg;

   localparam int SCREEN_W   = 640;
   localparam int SCREEN_H   = 480;
   localparam int BALL_SIZE  = 8;
   localparam int PADDLE_H   = 50;
   localparam int PADDLE_X_L = 20;
   localparam int PADDLE_X_R = 600;

   typedef enum logic [1:0] {
      CENTER     = 2'd0,
      WAIT_REACT = 2'd1,
      TRACK      = 2'd2
   } ai_state_e;

endpackage

// File: rtl/pong_paddle_ctrl_clamp_step.sv
// Moves a position toward a target by at most one step, honouring a dead zone,
// and clamps the result to [0, MAX_POS].
module clamp_step #(
   parameter int MAX_POS = 430
) (
   input  logic        [9:0]  i_cur,
   input  logic signed [10:0] i_target,
   input  logic        [9:0]  i_max_step,
   input  logic        [9:0]  i_dead_zone,
   output logic        [9:0]  o_next
);

   logic signed [11:0] w_cur;
   logic signed [11:0] w_tgt;
   logic signed [11:0] w_step;
   logic signed [11:0] w_dz;
   logic signed [11:0] w_dist;
   logic signed [11:0] w_abs;
   logic signed [11:0] w_cand;

   always_comb begin
      w_cur  = $signed({2'b00, i_cur});
      w_tgt  = $signed({i_target[10], i_target});
      w_step = $signed({2'b00, i_max_step});
      w_dz   = $signed({2'b00, i_dead_zone});
      w_dist = w_tgt - w_cur;
      w_abs  = (w_dist < 0) ? -w_dist : w_dist;

      if (w_abs <= w_dz)
         w_cand = w_cur;
      else if (w_abs <= w_step)
         w_cand = w_tgt;
      else if (w_dist < 0)
         w_cand = w_cur - w_step;
      else
         w_cand = w_cur + w_step;

      if (w_cand < 0)
         o_next = '0;
      else if (w_cand > $signed(12'(MAX_POS)))
         o_next = 10'(MAX_POS);
      else
         o_next = w_cand[9:0];
   end

endmodule

// File: rtl/pong_paddle_ctrl.sv
// One paddle's vertical position: button control or a ball-tracking AI with
// reaction delay, speed limit and dead zone. All motion happens on refr_tick.
//
//   state      | meaning
//   CENTER     | drift back to Y_START, wait for the ball to approach
//   WAIT_REACT | ball approaching, paddle frozen while the reaction delay counts
//   TRACK      | follow the ball centre, speed-limited, with dead zone
module pong_paddle_ctrl #(
   parameter int SCREEN_H    = pong_pkg::SCREEN_H,
   parameter int PADDLE_H    = pong_pkg::PADDLE_H,
   parameter int BALL_SIZE   = pong_pkg::BALL_SIZE,
   parameter int Y_START     = (SCREEN_H - PADDLE_H) / 2,
   parameter int PLAYER_STEP = 4,
   parameter int AI_STEP     = 2,
   parameter int DEAD_ZONE   = 4,
   parameter int REACT_TICKS = 6,
   parameter int SERVE_JUMP  = 16,
   parameter int SIDE_RIGHT  = 1
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       i_refr_tick,
   input  logic       i_mode_ai,
   input  logic       i_btn_up,
   input  logic       i_btn_dn,
   input  logic [9:0] i_ball_x,
   input  logic [9:0] i_ball_y,
   output logic [9:0] o_paddle_y,
   output logic [1:0] o_ai_state,
   output logic       o_moving
);
   import pong_pkg::*;

   localparam int MAX_Y  = SCREEN_H - PADDLE_H;
   localparam int AI_OFS = PADDLE_H / 2 - BALL_SIZE / 2;
   localparam int CNT_W  = $clog2(REACT_TICKS + 1);

   ai_state_e          r_state;
   logic [9:0]         r_paddle_y;
   logic               r_moving;
   logic [9:0]         r_ball_x_prev;
   logic [CNT_W-1:0]   r_react_cnt;
   logic               r_approaching;

   logic signed [10:0] w_dx;
   logic signed [10:0] w_adx;
   logic               w_serve;
   logic               w_approach;
   logic signed [10:0] w_cur;
   logic signed [10:0] w_ai_raw;
   logic signed [10:0] w_ai_tgt;
   logic signed [10:0] w_tgt;
   logic [9:0]         w_step;
   logic [9:0]         w_dz;
   logic [9:0]         w_next;
   logic [CNT_W-1:0]   w_cnt_inc;

   // Direction and serve are judged on this tick's ball_x so the FSM reacts in the same tick.
   always_comb begin
      w_dx    = $signed({1'b0, i_ball_x}) - $signed({1'b0, r_ball_x_prev});
      w_adx   = (w_dx < 0) ? -w_dx : w_dx;
      w_serve = (w_adx > 11'(SERVE_JUMP));
      if (i_ball_x == r_ball_x_prev)
         w_approach = r_approaching;
      else if (SIDE_RIGHT != 0)
         w_approach = (i_ball_x > r_ball_x_prev);
      else
         w_approach = (i_ball_x < r_ball_x_prev);
   end

   always_comb begin
      w_cur    = $signed({1'b0, r_paddle_y});
      w_ai_raw = $signed({1'b0, i_ball_y}) - 11'(AI_OFS);
      if (w_ai_raw < 0)
         w_ai_tgt = '0;
      else if (w_ai_raw > 11'(MAX_Y))
         w_ai_tgt = 11'(MAX_Y);
      else
         w_ai_tgt = w_ai_raw;

      w_tgt  = w_cur;
      w_step = 10'(AI_STEP);
      w_dz   = '0;
      if (!i_mode_ai) begin
         w_step = 10'(PLAYER_STEP);
         if (i_btn_up && !i_btn_dn)
            w_tgt = w_cur - 11'(PLAYER_STEP);
         else if (i_btn_dn && !i_btn_up)
            w_tgt = w_cur + 11'(PLAYER_STEP);
      end else begin
         case (r_state)
            CENTER: w_tgt = 11'(Y_START);
            TRACK: begin
               w_tgt = w_ai_tgt;
               w_dz  = 10'(DEAD_ZONE);
            end
            default: w_tgt = w_cur;
         endcase
      end
   end

   clamp_step #(
      .MAX_POS (MAX_Y)
   ) u_clamp_step (
      .i_cur       (r_paddle_y),
      .i_target    (w_tgt),
      .i_max_step  (w_step),
      .i_dead_zone (w_dz),
      .o_next      (w_next)
   );

   assign w_cnt_inc = r_react_cnt + 1'b1;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state       <= CENTER;
         r_paddle_y    <= 10'(Y_START);
         r_moving      <= 1'b0;
         r_ball_x_prev <= '0;
         r_react_cnt   <= '0;
         r_approaching <= 1'b0;
      end else if (i_refr_tick) begin
         r_paddle_y    <= w_next;
         r_moving      <= (w_next != r_paddle_y);
         r_ball_x_prev <= i_ball_x;
         r_approaching <= w_approach;
         if (!i_mode_ai) begin
            r_state     <= CENTER;
            r_react_cnt <= '0;
         end else begin
            case (r_state)
               CENTER: begin
                  if (w_approach && !w_serve) begin
                     r_state     <= WAIT_REACT;
                     r_react_cnt <= CNT_W'(1);
                  end
               end
               WAIT_REACT: begin
                  if (w_serve || !w_approach) begin
                     r_state     <= CENTER;
                     r_react_cnt <= '0;
                  end else begin
                     r_react_cnt <= w_cnt_inc;
                     if (w_cnt_inc >= CNT_W'(REACT_TICKS))
                        r_state <= TRACK;
                  end
               end
               TRACK: begin
                  if (w_serve || !w_approach) begin
                     r_state     <= CENTER;
                     r_react_cnt <= '0;
                  end
               end
               default: begin
                  r_state     <= CENTER;
                  r_react_cnt <= '0;
               end
            endcase
         end
      end
   end

   assign o_paddle_y = r_paddle_y;
   assign o_ai_state = r_state;
   assign o_moving   = r_moving;

endmodule

// File: tb/tb_pong_paddle_ctrl.sv
// Self-checking bench for pong_paddle_ctrl: vector table for basic player moves,
// then hand-written tick sequences for saturation, AI reaction, serve and reset.
module tb_pong_paddle_ctrl;

   logic       clk = 1'b0;
   logic       rstn;
   logic       tick;
   logic       ai;
   logic       up;
   logic       dn;
   logic [9:0] bx;
   logic [9:0] by;
   logic [9:0] y;
   logic [1:0] st;
   logic       mv;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int   y;
      int   st;
      logic mv;
   } exp_t;

   typedef struct {
      string name;
      logic  ai;
      logic  up;
      logic  dn;
      int    bx;
      int    by;
      int    ey;
      int    est;
      logic  emv;
   } vec_t;

   exp_t sb_q[$];
   vec_t vt[16];

   always #5 clk = ~clk;

   pong_paddle_ctrl dut (
      .clk         (clk),
      .rstn        (rstn),
      .i_refr_tick (tick),
      .i_mode_ai   (ai),
      .i_btn_up    (up),
      .i_btn_dn    (dn),
      .i_ball_x    (bx),
      .i_ball_y    (by),
      .o_paddle_y  (y),
      .o_ai_state  (st),
      .o_moving    (mv)
   );

   task automatic cmp(input string name, input exp_t e);
      n_checks++;
      if (y !== 10'(e.y) || st !== 2'(e.st) || mv !== e.mv) begin
         n_errors++;
         $display("FAIL %s: got y=%0d st=%0d mv=%0b, expected y=%0d st=%0d mv=%0b",
                  name, y, st, mv, e.y, e.st, e.mv);
      end
   endtask

   task automatic check_now(input string name, input int ey, input int est, input logic emv);
      exp_t e;
      e.y  = ey;
      e.st = est;
      e.mv = emv;
      cmp(name, e);
   endtask

   task automatic do_tick(input string name, input logic a_ai, input logic a_up, input logic a_dn,
                          input int a_bx, input int a_by, input int ey, input int est, input logic emv);
      exp_t e;
      @(negedge clk);
      ai   = a_ai;
      up   = a_up;
      dn   = a_dn;
      bx   = 10'(a_bx);
      by   = 10'(a_by);
      tick = 1'b1;
      e.y  = ey;
      e.st = est;
      e.mv = emv;
      sb_q.push_back(e);
      @(negedge clk);
      tick = 1'b0;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         cmp(name, sb_q.pop_front());
      end
   endtask

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
      $fatal(1, "timeout");
   end

   initial begin
      int py;
      int ey;
      int est;
      int cbx;

      rstn = 1'b0;
      tick = 1'b0;
      ai   = 1'b0;
      up   = 1'b0;
      dn   = 1'b0;
      bx   = '0;
      by   = '0;
      repeat (3) @(negedge clk);
      check_now("reset", 215, 0, 1'b0);
      rstn = 1'b1;

      for (int i = 0; i < 10; i++)
         vt[i] = '{"idle", 1'b0, 1'b0, 1'b0, 0, 0, 215, 0, 1'b0};
      vt[10] = '{"up_one",   1'b0, 1'b1, 1'b0, 0, 0, 211, 0, 1'b1};
      vt[11] = '{"both",     1'b0, 1'b1, 1'b1, 0, 0, 211, 0, 1'b0};
      vt[12] = '{"dn_one",   1'b0, 1'b0, 1'b1, 0, 0, 215, 0, 1'b1};
      vt[13] = '{"neither",  1'b0, 1'b0, 1'b0, 0, 0, 215, 0, 1'b0};
      vt[14] = '{"dn_again", 1'b0, 1'b0, 1'b1, 0, 0, 219, 0, 1'b1};
      vt[15] = '{"up_again", 1'b0, 1'b1, 1'b0, 0, 0, 215, 0, 1'b1};
      for (int i = 0; i < 16; i++)
         do_tick(vt[i].name, vt[i].ai, vt[i].up, vt[i].dn, vt[i].bx, vt[i].by,
                 vt[i].ey, vt[i].est, vt[i].emv);

      // Buttons without refr_tick must not move anything; moving holds its last value.
      @(negedge clk);
      up = 1'b1;
      repeat (6) @(negedge clk);
      check_now("hold_no_tick", 215, 0, 1'b1);
      up = 1'b0;

      py = 215;
      for (int k = 1; k <= 60; k++) begin
         ey = imax(215 - 4 * k, 0);
         do_tick("up_sat", 1'b0, 1'b1, 1'b0, 0, 0, ey, 0, logic'(ey != py));
         py = ey;
      end
      for (int k = 0; k < 5; k++)
         do_tick("both_at_0", 1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 1'b0);
      for (int k = 1; k <= 120; k++) begin
         ey = imin(4 * k, 430);
         do_tick("dn_sat", 1'b0, 1'b0, 1'b1, 0, 0, ey, 0, logic'(ey != py));
         py = ey;
      end

      // AI from 430 with a static ball: drift to 215, last step is 1 px.
      for (int k = 1; k <= 109; k++) begin
         ey = imax(430 - 2 * k, 215);
         do_tick("center_return", 1'b1, 1'b0, 1'b0, 0, 0, ey, 0, logic'(ey != py));
         py = ey;
      end

      do_tick("seed_serve", 1'b1, 1'b0, 1'b0, 100, 300, 215, 0, 1'b0);
      for (int n = 1; n <= 39; n++) begin
         cbx = 100 + 2 * n;
         if (n <= 5) begin
            ey  = 215;
            est = 1;
         end else begin
            ey  = imin(215 + 2 * (n - 6), 275);
            est = 2;
         end
         do_tick("react_track", 1'b1, 1'b0, 1'b0, cbx, 300, ey, est, logic'(ey != py));
         py = ey;
      end

      for (int k = 0; k <= 32; k++) begin
         ey = imax(275 - 2 * k, 215);
         do_tick("retreat_center", 1'b1, 1'b0, 1'b0, 176 - 2 * k, 300, ey, 0, logic'(ey != py));
         py = ey;
      end

      do_tick("serve_in_center", 1'b1, 1'b0, 1'b0, 580, 300, 215, 0, 1'b0);
      for (int n = 1; n <= 6; n++)
         do_tick("react2", 1'b1, 1'b0, 1'b0, 580 + 2 * n, 300, 215, (n < 6) ? 1 : 2, 1'b0);
      for (int j = 1; j <= 4; j++)
         do_tick("track2", 1'b1, 1'b0, 1'b0, 592 + 2 * j, 300, 215 + 2 * j, 2, 1'b1);
      do_tick("serve_track", 1'b1, 1'b0, 1'b0, 320, 300, 225, 0, 1'b1);
      do_tick("rewait", 1'b1, 1'b0, 1'b0, 322, 300, 223, 1, 1'b1);
      do_tick("serve_wait", 1'b1, 1'b0, 1'b0, 360, 300, 223, 0, 1'b0);

      do_tick("react3", 1'b1, 1'b0, 1'b0, 362, 0, 221, 1, 1'b1);
      for (int n = 2; n <= 6; n++)
         do_tick("react3", 1'b1, 1'b0, 1'b0, 360 + 2 * n, 0, 221, (n < 6) ? 1 : 2, 1'b0);
      py = 221;
      for (int j = 1; j <= 112; j++) begin
         ey = imax(221 - 2 * j, 3);
         do_tick("track_top", 1'b1, 1'b0, 1'b0, 372 + 2 * j, 0, ey, 2, logic'(ey != py));
         py = ey;
      end

      do_tick("mode_to_player", 1'b0, 1'b0, 1'b1, 598, 0, 7, 0, 1'b1);
      do_tick("player_dn", 1'b0, 1'b0, 1'b1, 600, 0, 11, 0, 1'b1);
      do_tick("mode_to_ai", 1'b1, 1'b0, 1'b1, 602, 0, 13, 1, 1'b1);

      @(negedge clk);
      #2 rstn = 1'b0;
      #1 check_now("async_reset", 215, 0, 1'b0);
      @(negedge clk);
      rstn = 1'b1;
      do_tick("post_reset_prev", 1'b1, 1'b0, 1'b0, 10, 0, 215, 1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
